// File: rtl/alu_sequencer.sv
// Command-driven initiator for the 4-bit ALU: accepts EXEC/LOAD/PEEK commands,
// keeps a 4-bit accumulator and {carry, overflow} flags, and returns one result per command.

module alu_sequencer_alu (
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  input  logic [2:0] op,
  output logic [3:0] x,
  output logic [1:0] ccr
);
  logic [4:0] sum;
  logic [4:0] dif;

  always_comb begin
    sum = {1'b0, n1} + {1'b0, n2};
    dif = {1'b0, n1} - {1'b0, n2};
    x   = '0;
    ccr = '0;
    case (op)
      3'b000: begin
        x   = sum[3:0];
        ccr = {sum[4], (n1[3] == n2[3]) && (sum[3] != n1[3])};
      end
      // carry on subtract is the borrow out of n1 - n2
      3'b001: begin
        x   = dif[3:0];
        ccr = {dif[4], (n1[3] != n2[3]) && (dif[3] != n1[3])};
      end
      3'b010: x = {n1[2:0], 1'b0};
      3'b011: x = 4'd0 - n1;
      3'b100: x = ~n1;
      3'b101: x = n1 & n2;
      3'b110: x = n1 | n2;
      default: x = n1 ^ n2;
    endcase
  end
endmodule

module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_ccr,
  output logic       res_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {EXEC = 2'b00, LOAD = 2'b01, PEEK = 2'b10, RSVD = 2'b11} mode_t;

  state_t     state;
  mode_t      mode_r;
  logic [2:0] op_r;
  logic [3:0] data_r;
  logic [3:0] acc;
  logic [1:0] flags;
  logic [3:0] alu_x;
  logic [1:0] alu_ccr;

  alu_sequencer_alu u_alu (
    .n1  (acc),
    .n2  (data_r),
    .op  (op_r),
    .x   (alu_x),
    .ccr (alu_ccr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= EXEC;
      op_r      <= '0;
      data_r    <= '0;
      acc       <= '0;
      flags     <= '0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ccr   <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode_r    <= mode_t'(cmd_mode);
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          state     <= RESP;
          case (mode_r)
            EXEC: begin
              acc      <= alu_x;
              flags    <= alu_ccr;
              res_data <= alu_x;
              res_ccr  <= alu_ccr;
            end
            LOAD: begin
              acc      <= data_r;
              res_data <= data_r;
              res_ccr  <= flags;
            end
            PEEK: begin
              res_data <= acc;
              res_ccr  <= flags;
            end
            default: begin
              res_data <= acc;
              res_ccr  <= flags;
              res_err  <= 1'b1;
            end
          endcase
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
